// File: rtl/ddr_rx_gearbox.sv
// DDR capture, RATIO-beat packer and FWFT output FIFO with sticky overflow.
// Optional popped-word counter output when DDR_RX_STAT_EN is defined.
module ddr_rx_gearbox #(
  parameter int DW         = 8,
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic                             din_en,
  input  logic [DW-1:0]                    din,
  output logic [DW*RATIO-1:0]              dout,
  output logic                             dout_vld,
  input  logic                             dout_rdy,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
`ifdef DDR_RX_STAT_EN
  ,
  output logic [15:0]                      word_cnt
`endif
);

  localparam int PAIRS = RATIO / 2;
  localparam int PW    = 2 * DW;
  localparam int WW    = DW * RATIO;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  logic [DW-1:0] pos_q;
  logic [DW-1:0] neg_q;
  logic          en_q;
  logic [WW-1:0] packer;
  logic [CW-1:0] pair_cnt;
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic [PW-1:0] pair;
  logic [WW-1:0] word_next;
  logic          last_pair;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) neg_q <= '0;
    else       neg_q <= din;
  end

  always_comb begin
    pair      = {neg_q, pos_q};
    word_next = packer;
    word_next[pair_cnt*PW +: PW] = pair;
    last_pair = (pair_cnt == CW'(PAIRS - 1));
    full      = (level == LW'(FIFO_DEPTH));
    push      = en_q && last_pair && !flush;
    pop       = dout_vld && dout_rdy && !flush;
    push_ok   = push && (!full || pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_q    <= '0;
      en_q     <= 1'b0;
      packer   <= '0;
      pair_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      // the pair sampled at this edge is discarded along with everything else
      pos_q    <= din;
      en_q     <= 1'b0;
      packer   <= '0;
      pair_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      pos_q <= din;
      en_q  <= din_en;
      if (en_q) begin
        if (last_pair) begin
          packer   <= '0;
          pair_cnt <= '0;
        end else begin
          packer   <= word_next;
          pair_cnt <= pair_cnt + CW'(1);
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= word_next;
  end

  assign dout_vld   = (level != '0);
  assign dout       = dout_vld ? mem[rd_ptr] : '0;
  assign fifo_level = level;

`ifdef DDR_RX_STAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      word_cnt <= '0;
    else if (flush) word_cnt <= '0;
    else if (pop)   word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ddr_rx_gearbox.sv
// Self-checking bench for ddr_rx_gearbox (DW=8, RATIO=4, FIFO_DEPTH=4).
// Word scoreboard plus a table of per-cycle vectors with expected level/overflow.
module tb_ddr_rx_gearbox;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        din_en = 1'b0;
  logic [7:0]  din = '0;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_rdy = 1'b0;
  logic        overflow;
  logic [2:0]  fifo_level;
`ifdef DDR_RX_STAT_EN
  logic [15:0] word_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddr_rx_gearbox #(.DW(8), .RATIO(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .din_en     (din_en),
    .din        (din),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
`ifdef DDR_RX_STAT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  typedef struct {
    bit       en;
    bit [7:0] a;
    bit [7:0] b;
    bit       rdy;
    bit       fl;
    int       lvl;
    bit       ovf;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_pk;
  int          m_cnt;
  bit          m_ovf;
  bit          m_pend;
  logic [15:0] m_pair;
  int          m_pops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pk = '0; m_cnt = 0; m_ovf = 0; m_pend = 0; m_pair = '0; m_pops = 0;
  endtask

  task automatic cycle(input bit en, input logic [7:0] a, input logic [7:0] b,
                       input bit rdy, input bit fl);
    bit pop;
    din_en = en; din = a; dout_rdy = rdy; flush = fl;
    pop = rdy && (m_q.size() > 0) && !fl;
    if (pop) begin
      chk("pop_word", dout, m_q[0]);
      void'(m_q.pop_front());
      m_pops++;
    end
    if (fl) begin
      m_q.delete();
      m_pk = '0; m_cnt = 0; m_ovf = 0; m_pops = 0;
    end else if (m_pend) begin
      m_pk[m_cnt*16 +: 16] = m_pair;
      if (m_cnt == 1) begin
        if (m_q.size() < 4) m_q.push_back(m_pk);
        else                m_ovf = 1;
        m_pk = '0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_pend = en && !fl;
    m_pair = {b, a};
    @(posedge clk);
    #2 din = b;
    @(negedge clk);
    #2;
    chk("level", 32'(fifo_level), 32'(m_q.size()));
    chk("vld", 32'(dout_vld), 32'(m_q.size() > 0));
    chk("ovf", 32'(overflow), 32'(m_ovf));
`ifdef DDR_RX_STAT_EN
    chk("word_cnt", 32'(word_cnt), 32'(m_pops));
`endif
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 8'h00, 8'h00, rdy, 1'b0);
  endtask

  task automatic add(input bit en, input bit [7:0] a, input bit [7:0] b,
                     input bit rdy, input bit fl, input int lvl, input bit ovf);
    vec_t v;
    v.en = en; v.a = a; v.b = b; v.rdy = rdy; v.fl = fl; v.lvl = lvl; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv[10];
    bit [7:0] v;
    lv = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
    v = 8'h01;
    // overflow: five words with no consumer, then drain and flush
    for (int i = 0; i < 10; i++) begin
      add(1, v, v + 8'h01, 0, 0, lv[i], 0);
      v = v + 8'h02;
    end
    add(0, 0, 0, 0, 0, 4, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 3 - i, 1);
    add(0, 0, 0, 0, 1, 0, 0);
    // full FIFO with simultaneous pop and push
    for (int i = 0; i < 8; i++) begin
      add(1, v, v + 8'h01, 0, 0, lv[i], 0);
      v = v + 8'h02;
    end
    add(1, v, v + 8'h01, 0, 0, 4, 0); v = v + 8'h02;
    add(1, v, v + 8'h01, 0, 0, 4, 0); v = v + 8'h02;
    add(0, 0, 0, 1, 0, 4, 0);
    add(0, 0, 0, 0, 0, 4, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 3 - i, 0);

    model_reset();
    #23;
    chk("rst_dout", dout, 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    rstn = 1'b1;
    @(negedge clk); #2;

    // two back-to-back pairs
    cycle(1, 8'h11, 8'h22, 0, 0);
    cycle(1, 8'h33, 8'h44, 0, 0);
    chk("t1_vld_early", 32'(dout_vld), 32'h0);
    idle(0);
    chk("t1_vld", 32'(dout_vld), 32'h1);
    chk("t1_dout", dout, 32'h44332211);
    chk("t1_level", 32'(fifo_level), 32'h1);
    idle(1);

    // gap between pairs of one word
    cycle(1, 8'h11, 8'h22, 0, 0);
    repeat (3) idle(0);
    chk("t2_vld_gap", 32'(dout_vld), 32'h0);
    cycle(1, 8'h33, 8'h44, 0, 0);
    idle(0);
    chk("t2_dout", dout, 32'h44332211);
    chk("t2_level", 32'(fifo_level), 32'h1);
    idle(1);
    idle(0);

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // flush discards a half-built word
    cycle(1, 8'h11, 8'h22, 0, 0);
    cycle(0, 8'h00, 8'h00, 0, 1);
    chk("t5_level", 32'(fifo_level), 32'h0);
    chk("t5_ovf", 32'(overflow), 32'h0);
`ifdef DDR_RX_STAT_EN
    chk("t5_word_cnt", 32'(word_cnt), 32'h0);
`endif
    cycle(1, 8'hAA, 8'hBB, 0, 0);
    cycle(1, 8'hCC, 8'hDD, 0, 0);
    idle(0);
    chk("t5_dout", dout, 32'hDDCCBBAA);
    idle(1);

    // reset in the middle of a word
    cycle(1, 8'h55, 8'h66, 0, 0);
    cycle(1, 8'h01, 8'h02, 0, 0);
    cycle(1, 8'h57, 8'h58, 0, 0);
    #1 rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_dout", dout, 32'h0);
    chk("t6_vld", 32'(dout_vld), 32'h0);
    chk("t6_level", 32'(fifo_level), 32'h0);
`ifdef DDR_RX_STAT_EN
    chk("t6_word_cnt", 32'(word_cnt), 32'h0);
`endif
    rstn = 1'b1;
    cycle(1, 8'h77, 8'h88, 0, 0);
    cycle(1, 8'h99, 8'hAA, 0, 0);
    idle(0);
    chk("t6_word", dout, 32'hAA998877);
    idle(1);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
